treasury_nonce_collector: RTL

TREASURY_NONCE_COLLECTOR -- requirements
Module: treasury_nonce_collector

---
 rtl/treasury_nonce_collector.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/treasury_nonce_collector.sv
// Collects golden nonces from parallel hasher lanes into a small output FIFO.
// Per-lane capture slots feed a round-robin arbiter; repeat hits on an occupied slot are counted as drops.
module treasury_nonce_collector #(
    parameter int LANES      = 27,
    parameter int NONCE_W    = 32,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [LANES-1:0]         lane_found,
    input  logic [LANES*NONCE_W-1:0] lane_nonce,
    input  logic                     job_new,
    input  logic [7:0]               job_id,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [NONCE_W-1:0]       out_nonce,
    output logic [4:0]               out_lane,
    output logic [7:0]               out_job,
    output logic [15:0]              drop_count,
    output logic                     busy
);
    localparam int PTR_W = (LANES > 1) ? $clog2(LANES) : 1;
    localparam int AW    = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int EW    = NONCE_W + 5 + 8;

    logic [LANES-1:0]   pending_r;
    logic [LANES-1:0]   capture_s;
    logic [LANES-1:0]   grant_mask_s;
    logic [NONCE_W-1:0] cap_nonce_r [LANES];
    logic [7:0]         cap_tag_r [LANES];
    logic [7:0]         tag_r;
    logic [PTR_W-1:0]   rr_ptr_r;
    logic [PTR_W-1:0]   grant_idx_s;
    logic [PTR_W-1:0]   rr_next_s;
    logic               grant_any_s;
    logic [EW-1:0]      fifo_mem_r [FIFO_DEPTH];
    logic [AW-1:0]      wr_ptr_r;
    logic [AW-1:0]      rd_ptr_r;
    logic [AW:0]        count_r;
    logic               empty_s;
    logic               full_s;
    logic               pop_s;
    logic               push_s;
    logic [15:0]        drop_count_r;
    logic [15:0]        drop_sum_s;
    logic [16:0]        drop_add_s;

    assign empty_s = (count_r == {(AW+1){1'b0}});
    assign full_s  = (count_r == (AW+1)'(FIFO_DEPTH));
    assign pop_s   = !empty_s && out_ready;

    // Classify each lane hit as a capture into a free slot or a drop on an occupied one.
    always_comb begin
        capture_s  = '0;
        drop_sum_s = 16'd0;
        for (int i = 0; i < LANES; i++) begin
            if (lane_found[i] && !job_new) begin
                if (pending_r[i]) begin
                    drop_sum_s = drop_sum_s + 16'd1;
                end else begin
                    capture_s[i] = 1'b1;
                end
            end else begin
                capture_s[i] = 1'b0;
            end
        end
        drop_add_s = {1'b0, drop_count_r} + {1'b0, drop_sum_s};
    end

    // Round-robin search upward from rr_ptr; a grant needs room in the FIFO this cycle.
    always_comb begin
        int idx;
        idx          = 0;
        grant_any_s  = 1'b0;
        grant_idx_s  = '0;
        grant_mask_s = '0;
        for (int k = 0; k < LANES; k++) begin
            idx = int'(rr_ptr_r) + k;
            if (idx >= LANES) begin
                idx = idx - LANES;
            end else begin
                idx = idx;
            end
            if (!grant_any_s && pending_r[idx]) begin
                grant_any_s = 1'b1;
                grant_idx_s = PTR_W'(idx);
            end else begin
                grant_any_s = grant_any_s;
            end
        end
        push_s = grant_any_s && (!full_s || pop_s) && !job_new;
        if (push_s) begin
            grant_mask_s[grant_idx_s] = 1'b1;
        end else begin
            grant_mask_s = '0;
        end
        if (grant_idx_s == PTR_W'(LANES - 1)) begin
            rr_next_s = '0;
        end else begin
            rr_next_s = grant_idx_s + PTR_W'(1);
        end
    end

    // Control state: pending flags, arbiter pointer, job tag, FIFO pointers and drop counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pending_r    <= '0;
            rr_ptr_r     <= '0;
            tag_r        <= 8'd0;
            wr_ptr_r     <= '0;
            rd_ptr_r     <= '0;
            count_r      <= '0;
            drop_count_r <= 16'd0;
        end else if (job_new) begin
            pending_r <= '0;
            rr_ptr_r  <= '0;
            tag_r     <= job_id;
            wr_ptr_r  <= '0;
            rd_ptr_r  <= '0;
            count_r   <= '0;
        end else begin
            pending_r    <= (pending_r & ~grant_mask_s) | capture_s;
            drop_count_r <= drop_add_s[16] ? 16'hFFFF : drop_add_s[15:0];
            if (push_s) begin
                rr_ptr_r <= rr_next_s;
                wr_ptr_r <= wr_ptr_r + AW'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1);
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + (AW+1)'(1);
                2'b01:   count_r <= count_r - (AW+1)'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    // Data storage needs no reset: it is only ever read behind a pending flag or FIFO occupancy.
    always_ff @(posedge clk) begin
        for (int i = 0; i < LANES; i++) begin
            if (capture_s[i]) begin
                cap_nonce_r[i] <= lane_nonce[i*NONCE_W +: NONCE_W];
                cap_tag_r[i]   <= tag_r;
            end
        end
        if (push_s) begin
            fifo_mem_r[wr_ptr_r] <= {cap_nonce_r[grant_idx_s], 5'(grant_idx_s), cap_tag_r[grant_idx_s]};
        end
    end

    // Head-of-FIFO presentation, forced to zero while nothing is queued.
    always_comb begin
        out_nonce = '0;
        out_lane  = 5'd0;
        out_job   = 8'd0;
        if (!empty_s) begin
            {out_nonce, out_lane, out_job} = fifo_mem_r[rd_ptr_r];
        end else begin
            out_nonce = '0;
        end
    end

    assign out_valid  = !empty_s;
    assign busy       = (|pending_r) || !empty_s;
    assign drop_count = drop_count_r;

endmodule
